// File: rtl/fetch_queue_pkg.sv
// Shared widths, device ids and types for the instruction prefetch queue.
package fetch_queue_pkg;
    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    localparam logic [2:0] DROM = 3'd2;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch unit bus: instruction memory request/response, redirect, and execute-side handshake.
interface fetch_queue_if #(
    parameter int ADDR_W  = fetch_queue_pkg::ADDR_W,
    parameter int INSTR_W = fetch_queue_pkg::INSTR_W
);
    logic               flush;
    logic [ADDR_W-1:0]  flush_pc;
    logic [ADDR_W-1:0]  addr;
    logic               rd;
    logic               hit;
    logic [2:0]         did;
    logic [INSTR_W-1:0] drom_data;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_fault;

    modport master (
        input  flush, flush_pc, hit, did, drom_data, instr_ready,
        output addr, rd, instr_valid, instr, instr_pc, instr_fault
    );

    modport slave (
        output flush, flush_pc, hit, did, drom_data, instr_ready,
        input  addr, rd, instr_valid, instr, instr_pc, instr_fault
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO with clear; only pointers and count are reset, storage is not.
module fetch_queue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
endmodule

// File: rtl/fetch_queue.sv
// Prefetching fetch unit: walks the fetch PC, issues one read per cycle and queues qualified responses.
module fetch_queue #(
    parameter int                ADDR_W   = fetch_queue_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_queue_pkg::INSTR_W,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master bus
);
    import fetch_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               fault;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d, tag_q, tag_d;
    logic              inflight_q, inflight_d;

    entry_t            push_entry, head;
    logic [CNT_W-1:0]  count;
    logic [OCC_W-1:0]  occupancy;
    logic              empty, full, push, pop, fifo_pop, resp, ok, rd;

    always_comb begin
        pop       = !empty && bus.instr_ready;
        fifo_pop  = pop && !bus.flush;
        // Entries already queued plus the read in flight, minus the one leaving now.
        occupancy = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
        rd        = rst_n && (state_q == RUN) && !bus.flush && (occupancy < OCC_W'(DEPTH));

        ok   = bus.hit && (bus.did == DROM);
        resp = inflight_q && (state_q == RUN) && !bus.flush;
        push = resp;
        push_entry.pc    = tag_q;
        push_entry.instr = ok ? bus.drom_data : '0;
        push_entry.fault = !ok;

        state_d = state_q;
        if (bus.flush)       state_d = RUN;
        else if (resp && !ok) state_d = FAULT;

        fpc_d = fpc_q;
        if (bus.flush) fpc_d = bus.flush_pc;
        else if (rd)   fpc_d = fpc_q + ADDR_W'(PC_STEP);

        inflight_d = rd;
        tag_d      = rd ? fpc_q : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fpc_q      <= RESET_PC;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    fetch_queue_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fifo_pop),
        .clear (bus.flush),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // Issue gating leaves room for every in-flight response.
    always_ff @(posedge clk) begin
        if (rst_n) assert (!(push && full && !fifo_pop));
    end

    assign bus.rd          = rd;
    assign bus.addr        = fpc_q;
    assign bus.instr_valid = !empty;
    assign bus.instr       = empty ? '0 : head.instr;
    assign bus.instr_pc    = empty ? '0 : head.pc;
    assign bus.instr_fault = empty ? 1'b0 : head.fault;
endmodule
